fetch_ctrl: RTL and testbench

Instruction-fetch sequencer sitting between the program counter and instruction memory of the RV32 core. Owns the fetch PC and issues in-order word requests over a req/gnt/rvalid memory handshake. Buffers returned instructions for decode behind a valid/ready handshake. Handles control-flow redirects by flushing buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_ctrl_if.sv | 28 ++
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch sequencer.
package fetch_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Memory request/response, redirect and decode handshake bundle of fetch_ctrl.
interface fetch_ctrl_if;
   import fetch_pkg::*;

   logic            mem_req;
   logic [XLEN-1:0] mem_addr;
   logic            mem_gnt;
   logic            mem_rvalid;
   logic [ILEN-1:0] mem_rdata;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            instr_valid;
   logic            instr_ready;
   logic [ILEN-1:0] instr;
   logic [XLEN-1:0] instr_pc;
   logic            fetch_fault;

   modport master (
      output mem_req, mem_addr, instr_valid, instr, instr_pc, fetch_fault,
      input  mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, instr_ready
   );

   modport slave (
      input  mem_req, mem_addr, instr_valid, instr, instr_pc, fetch_fault,
      output mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, instr_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; DEPTH must be a power of two so the
// pointers wrap naturally.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = count == '0;
   assign full    = count == CW'(DEPTH);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = storage[rd_ptr];

   // Flush drops everything queued; storage keeps stale words that are never read as valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            storage[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            storage[wr_ptr] <= wdata;
            wr_ptr          <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + CW'(1);
         end else if (do_pop && !do_push) begin
            count <= count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: credit-limited in-order word fetch, decode buffer,
// redirect flush. Define FETCH_TRACE_EN for simulation-only decode/fault tracing.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int              BUF_DEPTH = 2
) (
   input logic          clk,
   input logic          reset,
   fetch_ctrl_if.master bus
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_LIMIT = (CW+1)'(BUF_DEPTH);

   fetch_state_t    state;
   fetch_state_t    state_next;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [CW-1:0]   occupancy;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   discard;
   logic [CW:0]     credits_used;
   logic            redirect_take;
   logic            redirect_aligned;
   logic            issue;
   logic            resp_ack;
   logic            push;
   logic            pop;
   logic            addr_full;
   logic            addr_empty;
   logic            instr_full;
   logic            instr_empty;
   fetch_entry_t    push_entry;
   fetch_entry_t    head_entry;

   assign redirect_take    = bus.redirect && state == RUN;
   assign redirect_aligned = is_word_aligned(bus.redirect_pc);
   assign credits_used     = {1'b0, occupancy} + {1'b0, outstanding};
   assign issue            = bus.mem_req && bus.mem_gnt;
   assign resp_ack         = bus.mem_rvalid && !addr_empty;
   assign push             = resp_ack && !redirect_take && discard == '0 && state == RUN
                             && (!instr_full || pop);
   assign pop              = bus.instr_valid && bus.instr_ready && !redirect_take;
   assign push_entry       = '{instr: bus.mem_rdata, pc: resp_pc};

   assign bus.mem_addr = fetch_pc;
   assign bus.instr    = head_entry.instr;
   assign bus.instr_pc = head_entry.pc;

   // Addresses of requests in flight, so each in-order response knows its PC.
   fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(XLEN)) u_addr_q (
      .clk   (clk),
      .reset (reset),
      .push  (issue),
      .pop   (resp_ack),
      .flush (1'b0),
      .wdata (fetch_pc),
      .rdata (resp_pc),
      .full  (addr_full),
      .empty (addr_empty),
      .count (outstanding)
   );

   fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH($bits(fetch_entry_t))) u_instr_q (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect_take),
      .wdata (push_entry),
      .rdata (head_entry),
      .full  (instr_full),
      .empty (instr_empty),
      .count (occupancy)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (bus.redirect && !redirect_aligned) state_next = FAULT;
         FAULT:   state_next = FAULT;
         default: state_next = RUN;
      endcase
   end

   // Requests only go out while every buffered or in-flight word still has a slot.
   always_comb begin
      bus.mem_req     = 1'b0;
      bus.instr_valid = 1'b0;
      bus.fetch_fault = 1'b0;
      case (state)
         RUN: begin
            bus.mem_req     = !reset && !bus.redirect && !addr_full
                              && (credits_used < DEPTH_LIMIT);
            bus.instr_valid = !instr_empty;
         end
         FAULT:   bus.fetch_fault = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
      end else if (redirect_take) begin
         if (redirect_aligned) begin
            fetch_pc <= bus.redirect_pc;
         end
      end else if (issue) begin
         fetch_pc <= fetch_pc + 32'd4;
      end
   end

   // Everything still in flight after a redirect belongs to the old stream.
   always_ff @(posedge clk) begin
      if (reset) begin
         discard <= '0;
      end else if (redirect_take) begin
         discard <= resp_ack ? outstanding - CW'(1) : outstanding;
      end else if (resp_ack && discard != '0) begin
         discard <= discard - CW'(1);
      end
   end

`ifdef FETCH_TRACE_EN
   always_ff @(posedge clk) begin
      if (!reset && pop) begin
         $display("PC: 0x%h, Instruction: 0x%h", bus.instr_pc, bus.instr);
      end
      if (!reset && state == RUN && state_next == FAULT) begin
         $display("fetch_ctrl: misaligned redirect to 0x%h, entering fault state", bus.redirect_pc);
      end
   end
`else
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomised self-checking bench for fetch_ctrl against a queue-based memory and
// decode-stream reference model.
module tb_fetch_ctrl;
   import fetch_pkg::*;

   localparam int DEPTH = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          gcyc;
      bit          stale;
   } mem_txn_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_instr_t;

   logic clk = 1'b0;
   logic reset;

   fetch_ctrl_if ifc();

   fetch_ctrl #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.master)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   mem_txn_t    memq[$];
   exp_instr_t  mfifo[$];
   logic [31:0] issued_log[$];
   logic [31:0] popped_log[$];
   logic [31:0] m_pc;
   bit          m_fault;
   bit          gnt_random;
   bit          rv_random;
   bit          rv_enable;
   logic        last_req;
   logic        last_valid;
   logic        last_fault;
   logic [31:0] last_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return {addr[15:0], ~addr[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic bit rv_pending();
      return rv_enable && memq.size() > 0 && memq[0].gcyc < cyc;
   endfunction

   // One clock of memory/decoder environment plus reference-model comparison.
   task automatic run_cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
      logic       do_rv;
      logic       exp_req;
      logic       exp_valid;
      logic       take_redir;
      logic       do_pop;
      logic       hs;
      mem_txn_t   e;
      exp_instr_t n;
      do_rv = rv_pending() && (!rv_random || ($urandom_range(0, 2) != 0));
      ifc.mem_gnt     = gnt_random ? 1'($urandom_range(0, 1)) : 1'b1;
      ifc.mem_rvalid  = do_rv;
      ifc.mem_rdata   = do_rv ? memq[0].data : $urandom;
      ifc.instr_ready = rdy;
      ifc.redirect    = redir;
      ifc.redirect_pc = rpc;
      #4;
      exp_req   = !m_fault && !redir && ((mfifo.size() + memq.size()) < DEPTH);
      exp_valid = !m_fault && (mfifo.size() > 0);
      last_req   = ifc.mem_req;
      last_addr  = ifc.mem_addr;
      last_valid = ifc.instr_valid;
      last_fault = ifc.fetch_fault;
      checks++;
      if (ifc.mem_req !== exp_req) begin
         errors++;
         $display("[TB] FAIL mem_req cycle %0d: got %b expected %b", cyc, ifc.mem_req, exp_req);
      end
      if (exp_req) begin
         checks++;
         if (ifc.mem_addr !== m_pc) begin
            errors++;
            $display("[TB] FAIL mem_addr cycle %0d: got %h expected %h", cyc, ifc.mem_addr, m_pc);
         end
      end
      checks++;
      if (ifc.instr_valid !== exp_valid) begin
         errors++;
         $display("[TB] FAIL instr_valid cycle %0d: got %b expected %b", cyc, ifc.instr_valid, exp_valid);
      end
      if (exp_valid) begin
         checks++;
         if (ifc.instr_pc !== mfifo[0].pc) begin
            errors++;
            $display("[TB] FAIL instr_pc cycle %0d: got %h expected %h", cyc, ifc.instr_pc, mfifo[0].pc);
         end
         checks++;
         if (ifc.instr !== mfifo[0].word) begin
            errors++;
            $display("[TB] FAIL instr cycle %0d: got %h expected %h", cyc, ifc.instr, mfifo[0].word);
         end
      end
      checks++;
      if (ifc.fetch_fault !== m_fault) begin
         errors++;
         $display("[TB] FAIL fetch_fault cycle %0d: got %b expected %b", cyc, ifc.fetch_fault, m_fault);
      end
      take_redir = redir && !m_fault;
      do_pop     = exp_valid && rdy && !take_redir;
      hs         = ifc.mem_req && ifc.mem_gnt;
      if (do_pop) begin
         n = mfifo.pop_front();
         popped_log.push_back(n.pc);
      end
      if (do_rv) begin
         e = memq.pop_front();
         if (!e.stale && !take_redir && !m_fault) begin
            n.pc   = e.addr;
            n.word = e.data;
            mfifo.push_back(n);
         end
      end
      if (hs) begin
         e.addr  = ifc.mem_addr;
         e.data  = mem_word(ifc.mem_addr);
         e.gcyc  = cyc;
         e.stale = 1'b0;
         memq.push_back(e);
         issued_log.push_back(ifc.mem_addr);
      end
      if (exp_req && ifc.mem_gnt) m_pc = m_pc + 32'd4;
      if (take_redir) begin
         mfifo.delete();
         foreach (memq[i]) memq[i].stale = 1'b1;
         if (rpc[1:0] == 2'b00) m_pc = rpc;
         else m_fault = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic apply_reset(input bit check);
      reset           = 1'b1;
      ifc.mem_gnt     = 1'b0;
      ifc.mem_rvalid  = 1'b0;
      ifc.mem_rdata   = '0;
      ifc.instr_ready = 1'b0;
      ifc.redirect    = 1'b0;
      ifc.redirect_pc = '0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      memq.delete();
      mfifo.delete();
      issued_log.delete();
      popped_log.delete();
      m_pc    = RST_PC;
      m_fault = 1'b0;
      cyc     = 0;
      if (check) begin
         checks++;
         if (ifc.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset mem_req: got %b expected 0", ifc.mem_req); end
         checks++;
         if (ifc.mem_addr !== RST_PC) begin errors++; $display("[TB] FAIL reset mem_addr: got %h expected %h", ifc.mem_addr, RST_PC); end
         checks++;
         if (ifc.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset instr_valid: got %b expected 0", ifc.instr_valid); end
         checks++;
         if (ifc.instr !== 32'h0) begin errors++; $display("[TB] FAIL reset instr: got %h expected 0", ifc.instr); end
         checks++;
         if (ifc.instr_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset instr_pc: got %h expected 0", ifc.instr_pc); end
         checks++;
         if (ifc.fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL reset fetch_fault: got %b expected 0", ifc.fetch_fault); end
      end
      reset = 1'b0;
   endtask

   task automatic test_reset();
      gnt_random = 1'b0;
      rv_random  = 1'b0;
      rv_enable  = 1'b1;
      apply_reset(1'b1);
      run_cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (last_req !== 1'b1) begin errors++; $display("[TB] FAIL first_req: got %b expected 1", last_req); end
      checks++;
      if (last_addr !== RST_PC) begin errors++; $display("[TB] FAIL first_addr: got %h expected %h", last_addr, RST_PC); end
   endtask

   task automatic test_stream();
      apply_reset(1'b0);
      for (int i = 0; i < 12; i++) run_cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (popped_log.size() < 3) begin
         errors++;
         $display("[TB] FAIL stream_count: got %0d expected at least 3", popped_log.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (popped_log[i] !== 32'(i * 4)) begin
               errors++;
               $display("[TB] FAIL stream_pc[%0d]: got %h expected %h", i, popped_log[i], 32'(i * 4));
            end
         end
      end
   endtask

   task automatic test_stall();
      apply_reset(1'b0);
      for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b0, 32'h0);
      checks++;
      if (issued_log.size() != DEPTH) begin
         errors++;
         $display("[TB] FAIL stall_requests: got %0d expected %0d", issued_log.size(), DEPTH);
      end
      checks++;
      if (last_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req_low: got %b expected 0", last_req); end
      issued_log.delete();
      for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (popped_log.size() < 2 || issued_log.size() < 1) begin
         errors++;
         $display("[TB] FAIL stall_drain: got %0d pops %0d issues expected at least 2 and 1", popped_log.size(), issued_log.size());
      end else begin
         checks++;
         if (popped_log[0] !== 32'h0) begin errors++; $display("[TB] FAIL drain_pc0: got %h expected 0", popped_log[0]); end
         checks++;
         if (popped_log[1] !== 32'h4) begin errors++; $display("[TB] FAIL drain_pc1: got %h expected 4", popped_log[1]); end
         checks++;
         if (issued_log[0] !== 32'h8) begin errors++; $display("[TB] FAIL resume_addr: got %h expected 8", issued_log[0]); end
      end
   endtask

   task automatic test_redirect_inflight();
      apply_reset(1'b0);
      rv_enable = 1'b0;
      run_cycle(1'b1, 1'b0, 32'h0);
      run_cycle(1'b1, 1'b0, 32'h0);
      popped_log.delete();
      run_cycle(1'b1, 1'b1, 32'h100);
      checks++;
      if (last_req !== 1'b0) begin errors++; $display("[TB] FAIL redir_req_low: got %b expected 0", last_req); end
      rv_enable = 1'b1;
      run_cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (last_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_valid_low: got %b expected 0", last_valid); end
      for (int i = 0; i < 12; i++) run_cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (popped_log.size() < 2) begin
         errors++;
         $display("[TB] FAIL redir_pops: got %0d expected at least 2", popped_log.size());
      end
      foreach (popped_log[i]) begin
         checks++;
         if (popped_log[i] !== 32'h100 + 32'(i * 4)) begin
            errors++;
            $display("[TB] FAIL redir_stream[%0d]: got %h expected %h", i, popped_log[i], 32'h100 + 32'(i * 4));
         end
      end
   endtask

   task automatic test_redirect_coincident();
      bit found;
      apply_reset(1'b0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (rv_pending() && mfifo.size() > 0) found = 1'b1;
         else run_cycle(1'b1, 1'b0, 32'h0);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("[TB] FAIL coincident_setup: got timeout expected rvalid with valid instr");
      end
      popped_log.delete();
      issued_log.delete();
      run_cycle(1'b1, 1'b1, 32'h40);
      run_cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (last_valid !== 1'b0) begin errors++; $display("[TB] FAIL coincident_valid_low: got %b expected 0", last_valid); end
      for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (popped_log.size() < 1 || issued_log.size() < 1) begin
         errors++;
         $display("[TB] FAIL coincident_resume: got %0d pops %0d issues expected at least 1 each", popped_log.size(), issued_log.size());
      end else begin
         checks++;
         if (popped_log[0] !== 32'h40) begin errors++; $display("[TB] FAIL coincident_pc: got %h expected 40", popped_log[0]); end
         checks++;
         if (issued_log[0] !== 32'h40) begin errors++; $display("[TB] FAIL coincident_addr: got %h expected 40", issued_log[0]); end
      end
   endtask

   task automatic test_fault();
      apply_reset(1'b0);
      for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 32'h0);
      run_cycle(1'b1, 1'b1, 32'h102);
      run_cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (last_fault !== 1'b1) begin errors++; $display("[TB] FAIL fault_rise: got %b expected 1", last_fault); end
      issued_log.delete();
      run_cycle(1'b1, 1'b1, 32'h200);
      for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (issued_log.size() != 0) begin errors++; $display("[TB] FAIL fault_no_fetch: got %0d requests expected 0", issued_log.size()); end
      checks++;
      if (last_fault !== 1'b1) begin errors++; $display("[TB] FAIL fault_sticky: got %b expected 1", last_fault); end
      apply_reset(1'b0);
      run_cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (last_fault !== 1'b0) begin errors++; $display("[TB] FAIL fault_cleared: got %b expected 0", last_fault); end
      checks++;
      if (last_req !== 1'b1 || last_addr !== RST_PC) begin
         errors++;
         $display("[TB] FAIL fault_refetch: got req %b addr %h expected req 1 addr %h", last_req, last_addr, RST_PC);
      end
   endtask

   task automatic test_wrap();
      apply_reset(1'b0);
      for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 32'h0);
      issued_log.delete();
      run_cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
      for (int i = 0; i < 10; i++) run_cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (issued_log.size() < 2) begin
         errors++;
         $display("[TB] FAIL wrap_count: got %0d expected at least 2", issued_log.size());
      end else begin
         checks++;
         if (issued_log[0] !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_first: got %h expected fffffffc", issued_log[0]); end
         checks++;
         if (issued_log[1] !== 32'h0) begin errors++; $display("[TB] FAIL wrap_second: got %h expected 0", issued_log[1]); end
      end
   endtask

   task automatic test_random();
      logic [31:0] rpc;
      apply_reset(1'b0);
      gnt_random = 1'b1;
      rv_random  = 1'b1;
      for (int i = 0; i < 600; i++) begin
         rpc        = $urandom;
         rpc[1:0]   = 2'b00;
         run_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0, rpc);
      end
      gnt_random = 1'b0;
      rv_random  = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      $display("[TB] starting fetch_ctrl bench");
      test_reset();
      test_stream();
      test_stall();
      test_redirect_inflight();
      test_redirect_coincident();
      test_fault();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
